ieee488_device: RTL and testbench

Device-side IEEE-488 bus engine: the responder at the far end of the PET's controller/talker/listener port. It lets an emulated peripheral, such as a disk drive, sit on the same bus wires the PET I/O block drives. It performs acceptor handshake (NRFD/NDAC), source handshake (DAV/EOI), and ATN command decoding (LISTEN/TALK/UNLISTEN/UNTALK/secondary). It presents byte streams to a device controller on a simple valid/ack interface.

---
 rtl/ieee488_pkg.sv | 52 +++++
 rtl/ieee488_source.sv | 87 ++++++++
 rtl/ieee488_device.sv | 158 +++++++++++++++
 tb/tb_ieee488_device.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ieee488_pkg.sv
// rtl/ieee488_pkg.sv - IEEE-488 device-side command constants, FSM states, secondary-address decode
package ieee488_pkg;

  // Bus command bytes as seen after inverting the active-low data lines.
  localparam logic [7:0] CMD_LISTEN   = 8'h20;
  localparam logic [7:0] CMD_UNLISTEN = 8'h3F;
  localparam logic [7:0] CMD_TALK     = 8'h40;
  localparam logic [7:0] CMD_UNTALK   = 8'h5F;
  localparam logic [7:0] CMD_SECOND   = 8'h60;
  localparam logic [7:0] CMD_CLOSE    = 8'hE0;
  localparam logic [7:0] CMD_OPEN     = 8'hF0;

  typedef enum logic [1:0] {
    A_IDLE   = 2'd0,
    A_READY  = 2'd1,
    A_ACCEPT = 2'd2,
    A_WAIT   = 2'd3
  } acc_state_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_DAV     = 2'd2,
    S_RELEASE = 2'd3
  } src_state_t;

  typedef enum logic [1:0] {
    SA_DATA  = 2'd0,
    SA_CLOSE = 2'd1,
    SA_OPEN  = 2'd2
  } sa_cmd_t;

  typedef struct packed {
    logic    hit;
    sa_cmd_t cmd;
  } sa_dec_t;

  // Classifies a command byte as one of the secondary-address families by its upper nibble.
  function automatic sa_dec_t sa_decode(input logic [7:0] b);
    sa_dec_t d;
    d.hit = 1'b1;
    d.cmd = SA_DATA;
    case (b[7:4])
      CMD_SECOND[7:4]: d.cmd = SA_DATA;
      CMD_CLOSE[7:4]:  d.cmd = SA_CLOSE;
      CMD_OPEN[7:4]:   d.cmd = SA_OPEN;
      default:         d.hit = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ieee488_source.sv
// rtl/ieee488_source.sv - IEEE-488 source handshake (DAV/EOI/data) for the talker role
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   ce              1 MHz clock enable; state advances only when set
//   enable          talking and ATN released; dropping it aborts the byte
//   nrfd_i, ndac_i  listener handshake lines, active-low
//   tx_data/tx_eoi/tx_valid  byte to send, held until tx_done
//   data_o, dav_o, eoi_o     driven bus lines, active-low, 1 = released
//   tx_done         one-clk pulse when a listener accepted the byte
module ieee488_source
  import ieee488_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       enable,
  input  logic       nrfd_i,
  input  logic       ndac_i,
  input  logic [7:0] tx_data,
  input  logic       tx_eoi,
  input  logic       tx_valid,
  output logic [7:0] data_o,
  output logic       dav_o,
  output logic       eoi_o,
  output logic       tx_done
);

  src_state_t state, state_next;
  logic [7:0] data_d;
  logic       dav_d, eoi_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      data_o  <= 8'hFF;
      dav_o   <= 1'b1;
      eoi_o   <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (ce) begin
        state   <= state_next;
        data_o  <= data_d;
        dav_o   <= dav_d;
        eoi_o   <= eoi_d;
        tx_done <= (state == S_DAV) && (state_next == S_RELEASE);
      end
    end
  end

  always_comb begin
    state_next = state;
    if (!enable) begin
      // ATN or loss of talker status: drop the byte without completing it.
      state_next = S_IDLE;
    end else begin
      case (state)
        // nrfd_i=1 with ndac_i=1 means nobody is listening, so keep waiting.
        S_IDLE:    if (tx_valid && nrfd_i && !ndac_i) state_next = S_SETTLE;
        S_SETTLE:  state_next = S_DAV;
        S_DAV:     if (ndac_i) state_next = S_RELEASE;
        S_RELEASE: if (!ndac_i) state_next = S_IDLE;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  // Outputs are computed for the state being entered and registered with it.
  always_comb begin
    data_d = 8'hFF;
    eoi_d  = 1'b1;
    dav_d  = 1'b1;
    case (state_next)
      S_SETTLE: begin
        data_d = ~tx_data;
        eoi_d  = ~tx_eoi;
      end
      S_DAV: begin
        data_d = data_o;
        eoi_d  = eoi_o;
        dav_d  = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ieee488_device.sv
// rtl/ieee488_device.sv - IEEE-488 device-side bus engine: acceptor, ATN command decoder, talker
// Ports:
//   clk, reset, ce             clock, async active-high reset, 1 MHz clock enable
//   ieee488_*_i                bus lines in, active-low
//   ieee488_*_o                bus lines out, active-low, 1 / 8'hFF = released
//   rx_data/rx_eoi/rx_valid    received byte; rx_ack pulse consumes it
//   tx_data/tx_eoi/tx_valid    byte to talk; tx_done pulse when accepted
//   listening, talking         addressed state
//   sa_strobe/sa_cmd/sa_value  secondary address following our LISTEN/TALK
module ieee488_device
  import ieee488_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR = 8'd8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic [7:0] ieee488_data_i,
  input  logic       ieee488_atn_i,
  input  logic       ieee488_dav_i,
  input  logic       ieee488_eoi_i,
  input  logic       ieee488_nrfd_i,
  input  logic       ieee488_ndac_i,
  output logic [7:0] ieee488_data_o,
  output logic       ieee488_dav_o,
  output logic       ieee488_eoi_o,
  output logic       ieee488_nrfd_o,
  output logic       ieee488_ndac_o,
  output logic [7:0] rx_data,
  output logic       rx_eoi,
  output logic       rx_valid,
  input  logic       rx_ack,
  input  logic [7:0] tx_data,
  input  logic       tx_eoi,
  input  logic       tx_valid,
  output logic       tx_done,
  output logic       listening,
  output logic       talking,
  output logic       sa_strobe,
  output logic [1:0] sa_cmd,
  output logic [3:0] sa_value
);

  localparam logic [7:0] MY_LISTEN = CMD_LISTEN | DEV_ADDR;
  localparam logic [7:0] MY_TALK   = CMD_TALK | DEV_ADDR;

  acc_state_t a_state, a_next;
  logic       under_atn, engaged, sink_ready, latch_byte;
  logic       nrfd_d, ndac_d;
  logic       after_addr;   // previous ATN byte was our LISTEN or TALK
  logic [7:0] bus_byte;
  sa_dec_t    sa_d;

  assign under_atn  = !ieee488_atn_i;
  assign engaged    = under_atn || listening;
  assign sink_ready = under_atn || !rx_valid;   // commands are always taken
  assign bus_byte   = ~ieee488_data_i;
  assign sa_d       = sa_decode(bus_byte);
  assign latch_byte = (a_state == A_READY) && (a_next == A_ACCEPT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_state        <= A_IDLE;
      ieee488_nrfd_o <= 1'b1;
      ieee488_ndac_o <= 1'b1;
      rx_data        <= 8'h00;
      rx_eoi         <= 1'b0;
      rx_valid       <= 1'b0;
      listening      <= 1'b0;
      talking        <= 1'b0;
      sa_strobe      <= 1'b0;
      sa_cmd         <= SA_DATA;
      sa_value       <= 4'h0;
      after_addr     <= 1'b0;
    end else begin
      sa_strobe <= 1'b0;
      // Ack is applied first so a byte latched in the same clk stays valid.
      if (rx_ack) rx_valid <= 1'b0;
      if (ce) begin
        a_state        <= a_next;
        ieee488_nrfd_o <= nrfd_d;
        ieee488_ndac_o <= ndac_d;
        if (latch_byte) begin
          if (under_atn) begin
            after_addr <= (bus_byte == MY_LISTEN) || (bus_byte == MY_TALK);
            if (bus_byte == MY_LISTEN) begin
              listening <= 1'b1;
              talking   <= 1'b0;
            end else if (bus_byte == CMD_UNLISTEN) begin
              listening <= 1'b0;
            end else if (bus_byte == MY_TALK) begin
              talking   <= 1'b1;
              listening <= 1'b0;
            end else if ((bus_byte & 8'hE0) == CMD_TALK || bus_byte == CMD_UNTALK) begin
              // Another device was made talker, or UNTALK.
              talking <= 1'b0;
            end else if (sa_d.hit && after_addr) begin
              sa_strobe <= 1'b1;
              sa_cmd    <= sa_d.cmd;
              sa_value  <= bus_byte[3:0];
            end
          end else begin
            rx_valid <= 1'b1;
            rx_data  <= bus_byte;
            rx_eoi   <= ~ieee488_eoi_i;
          end
        end
      end
    end
  end

  always_comb begin
    a_next = a_state;
    if (!engaged) begin
      a_next = A_IDLE;
    end else begin
      case (a_state)
        A_IDLE:   if (ieee488_dav_i && sink_ready) a_next = A_READY;
        A_READY:  if (!ieee488_dav_i) a_next = A_ACCEPT;
        A_ACCEPT: a_next = A_WAIT;
        A_WAIT:   if (ieee488_dav_i) a_next = A_IDLE;
        default:  a_next = A_IDLE;
      endcase
    end
  end

  always_comb begin
    nrfd_d = 1'b1;
    ndac_d = 1'b1;
    if (engaged) begin
      case (a_next)
        A_IDLE: begin
          nrfd_d = 1'b0;
          ndac_d = 1'b0;
        end
        A_READY:  ndac_d = 1'b0;
        default:  nrfd_d = 1'b0;   // A_ACCEPT, A_WAIT: byte taken, hold off next
      endcase
    end
  end

  ieee488_source u_source (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .enable   (talking && ieee488_atn_i),
    .nrfd_i   (ieee488_nrfd_i),
    .ndac_i   (ieee488_ndac_i),
    .tx_data  (tx_data),
    .tx_eoi   (tx_eoi),
    .tx_valid (tx_valid),
    .data_o   (ieee488_data_o),
    .dav_o    (ieee488_dav_o),
    .eoi_o    (ieee488_eoi_o),
    .tx_done  (tx_done)
  );

endmodule

// File: tb/tb_ieee488_device.sv
// tb/tb_ieee488_device.sv - directed self-checking bench for ieee488_device
module tb_ieee488_device;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] ce_cnt = 2'd0;
  logic       ce;
  logic [7:0] data_i;
  logic       atn_i, dav_i, eoi_i, nrfd_i, ndac_i;
  logic [7:0] data_o;
  logic       dav_o, eoi_o, nrfd_o, ndac_o;
  logic [7:0] rx_data;
  logic       rx_eoi, rx_valid, rx_ack;
  logic [7:0] tx_data;
  logic       tx_eoi, tx_valid, tx_done;
  logic       listening, talking, sa_strobe;
  logic [1:0] sa_cmd;
  logic [3:0] sa_value;

  int n_cmp = 0;
  int n_bad = 0;
  int sa_count = 0;
  int done_count = 0;
  logic [1:0] sa_cmd_seen = 2'd3;
  logic [3:0] sa_val_seen = 4'h0;

  localparam int L_NRFD = 0, L_NDAC = 1, L_DAV = 2, L_READY = 3;

  ieee488_device #(.DEV_ADDR(8'd8)) dut (
    .clk(clk), .reset(reset), .ce(ce),
    .ieee488_data_i(data_i), .ieee488_atn_i(atn_i), .ieee488_dav_i(dav_i),
    .ieee488_eoi_i(eoi_i), .ieee488_nrfd_i(nrfd_i), .ieee488_ndac_i(ndac_i),
    .ieee488_data_o(data_o), .ieee488_dav_o(dav_o), .ieee488_eoi_o(eoi_o),
    .ieee488_nrfd_o(nrfd_o), .ieee488_ndac_o(ndac_o),
    .rx_data(rx_data), .rx_eoi(rx_eoi), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .tx_data(tx_data), .tx_eoi(tx_eoi), .tx_valid(tx_valid), .tx_done(tx_done),
    .listening(listening), .talking(talking),
    .sa_strobe(sa_strobe), .sa_cmd(sa_cmd), .sa_value(sa_value)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ce_cnt <= ce_cnt + 2'd1;
  assign ce = (ce_cnt == 2'd3);

  always @(negedge clk) begin
    if (sa_strobe) begin
      sa_count    = sa_count + 1;
      sa_cmd_seen = sa_cmd;
      sa_val_seen = sa_value;
    end
    if (tx_done) done_count = done_count + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic ce_tick();
    do @(posedge clk); while (ce !== 1'b1);
    #1;
  endtask

  function automatic logic bus_line(input int sel);
    case (sel)
      L_NRFD:  return nrfd_o;
      L_NDAC:  return ndac_o;
      L_DAV:   return dav_o;
      default: return nrfd_o & ~ndac_o;
    endcase
  endfunction

  task automatic wait_line(input int sel, input logic val, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (bus_line(sel) === val) begin
        ok = 1'b1;
        break;
      end
      ce_tick();
    end
  endtask

  // Controller talking one byte to the device.
  task automatic ctl_send(input logic [7:0] b, input logic eoi, output logic ok);
    logic ok1, ok2, ok3;
    wait_line(L_READY, 1'b1, ok1);
    data_i = ~b;
    eoi_i  = ~eoi;
    ce_tick();
    dav_i = 1'b0;
    wait_line(L_NDAC, 1'b1, ok2);
    dav_i  = 1'b1;
    data_i = 8'hFF;
    eoi_i  = 1'b1;
    wait_line(L_NDAC, 1'b0, ok3);
    ok = ok1 & ok2 & ok3;
  endtask

  // Bench listening to one byte talked by the device.
  task automatic lst_recv(output logic [7:0] b, output logic eoi, output logic ok);
    logic ok1, ok2;
    nrfd_i = 1'b1;
    ndac_i = 1'b0;
    wait_line(L_DAV, 1'b0, ok1);
    b   = ~data_o;
    eoi = ~eoi_o;
    nrfd_i = 1'b0;
    ndac_i = 1'b1;
    wait_line(L_DAV, 1'b1, ok2);
    ndac_i = 1'b0;
    ok = ok1 & ok2;
  endtask

  task automatic test_reset();
    n_cmp++; if (data_o !== 8'hFF) begin n_bad++; $display("FAIL rst_data_o: got %h want ff", data_o); end
    n_cmp++; if ({dav_o, eoi_o, nrfd_o, ndac_o} !== 4'hF) begin n_bad++; $display("FAIL rst_lines: got %b want 1111", {dav_o, eoi_o, nrfd_o, ndac_o}); end
    n_cmp++; if ({rx_valid, tx_done, sa_strobe, listening, talking} !== 5'b0) begin n_bad++; $display("FAIL rst_flags: got %b want 00000", {rx_valid, tx_done, sa_strobe, listening, talking}); end
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL rst_rx_data: got %h want 00", rx_data); end
  endtask

  task automatic test_listen_sa();
    logic ok;
    int s0;
    s0 = sa_count;
    atn_i = 1'b0;
    ctl_send(8'h28, 1'b0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL listen_hs: got %b want 1", ok); end
    ctl_send(8'h6F, 1'b0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL sa_hs: got %b want 1", ok); end
    atn_i = 1'b1;
    ce_tick();
    n_cmp++; if (listening !== 1'b1) begin n_bad++; $display("FAIL listen_set: got %b want 1", listening); end
    n_cmp++; if (sa_count !== s0 + 1) begin n_bad++; $display("FAIL sa_count: got %0d want %0d", sa_count, s0 + 1); end
    n_cmp++; if ({sa_cmd_seen, sa_val_seen} !== {2'd0, 4'hF}) begin n_bad++; $display("FAIL sa_data15: got %0d/%0d want 0/15", sa_cmd_seen, sa_val_seen); end
  endtask

  task automatic test_rx();
    logic ok;
    ctl_send(8'h41, 1'b1, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rx_hs: got %b want 1", ok); end
    n_cmp++; if ({rx_valid, rx_data, rx_eoi} !== {1'b1, 8'h41, 1'b1}) begin n_bad++; $display("FAIL rx_byte: got v%b %h e%b want v1 41 e1", rx_valid, rx_data, rx_eoi); end
    repeat (3) ce_tick();
    n_cmp++; if (nrfd_o !== 1'b0) begin n_bad++; $display("FAIL rx_hold_nrfd: got %b want 0", nrfd_o); end
    rx_ack = 1'b1;
    @(posedge clk); #1;
    rx_ack = 1'b0;
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL rx_ack: got %b want 0", rx_valid); end
    ctl_send(8'h55, 1'b0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rx_hs2: got %b want 1", ok); end
    n_cmp++; if ({rx_valid, rx_data, rx_eoi} !== {1'b1, 8'h55, 1'b0}) begin n_bad++; $display("FAIL rx_byte2: got v%b %h e%b want v1 55 e0", rx_valid, rx_data, rx_eoi); end
    rx_ack = 1'b1;
    @(posedge clk); #1;
    rx_ack = 1'b0;
  endtask

  task automatic test_talk();
    logic ok;
    logic [7:0] b;
    logic e;
    int s0, d0;
    atn_i = 1'b0;
    ctl_send(8'h48, 1'b0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL talk_hs: got %b want 1", ok); end
    n_cmp++; if ({talking, listening} !== 2'b10) begin n_bad++; $display("FAIL talk_set: got t%b l%b want t1 l0", talking, listening); end
    s0 = sa_count;
    ctl_send(8'h60, 1'b0, ok);
    n_cmp++; if (sa_count !== s0 + 1 || {sa_cmd_seen, sa_val_seen} !== 6'd0) begin n_bad++; $display("FAIL talk_sa: got n%0d %0d/%0d want n%0d 0/0", sa_count, sa_cmd_seen, sa_val_seen, s0 + 1); end
    atn_i = 1'b1;
    d0 = done_count;
    tx_data = 8'h12; tx_eoi = 1'b0; tx_valid = 1'b1;
    nrfd_i = 1'b1; ndac_i = 1'b1;
    repeat (6) ce_tick();
    n_cmp++; if ({dav_o, data_o} !== {1'b1, 8'hFF}) begin n_bad++; $display("FAIL no_listener: got dav%b %h want dav1 ff", dav_o, data_o); end
    lst_recv(b, e, ok);
    n_cmp++; if ({ok, b, e} !== {1'b1, 8'h12, 1'b0}) begin n_bad++; $display("FAIL tx_byte1: got ok%b %h e%b want ok1 12 e0", ok, b, e); end
    tx_data = 8'h34; tx_eoi = 1'b1;
    lst_recv(b, e, ok);
    n_cmp++; if ({ok, b, e} !== {1'b1, 8'h34, 1'b1}) begin n_bad++; $display("FAIL tx_byte2: got ok%b %h e%b want ok1 34 e1", ok, b, e); end
    tx_valid = 1'b0;
    ce_tick();
    n_cmp++; if (done_count !== d0 + 2) begin n_bad++; $display("FAIL tx_done_count: got %0d want %0d", done_count - d0, 2); end
  endtask

  task automatic test_abort();
    logic ok;
    int d0;
    d0 = done_count;
    tx_data = 8'h77; tx_eoi = 1'b1; tx_valid = 1'b1;
    nrfd_i = 1'b1; ndac_i = 1'b0;
    wait_line(L_DAV, 1'b0, ok);
    n_cmp++; if ({ok, eoi_o, data_o} !== {1'b1, 1'b0, 8'h88}) begin n_bad++; $display("FAIL abort_pre: got ok%b eoi%b %h want ok1 eoi0 88", ok, eoi_o, data_o); end
    atn_i = 1'b0;
    ce_tick();
    n_cmp++; if ({dav_o, eoi_o, data_o} !== {2'b11, 8'hFF}) begin n_bad++; $display("FAIL abort_release: got dav%b eoi%b %h want dav1 eoi1 ff", dav_o, eoi_o, data_o); end
    n_cmp++; if (ndac_o !== 1'b0) begin n_bad++; $display("FAIL abort_ndac: got %b want 0", ndac_o); end
    n_cmp++; if (talking !== 1'b1) begin n_bad++; $display("FAIL abort_talking: got %b want 1", talking); end
    tx_valid = 1'b0;
    nrfd_i = 1'b1; ndac_i = 1'b1;
    repeat (4) ce_tick();
    n_cmp++; if (done_count !== d0) begin n_bad++; $display("FAIL abort_no_done: got %0d want 0", done_count - d0); end
    ctl_send(8'h5F, 1'b0, ok);
    n_cmp++; if ({ok, talking} !== 2'b10) begin n_bad++; $display("FAIL untalk: got ok%b t%b want ok1 t0", ok, talking); end
  endtask

  task automatic test_commands();
    logic ok;
    int s0;
    ctl_send(8'h29, 1'b0, ok);
    n_cmp++; if ({ok, listening} !== 2'b10) begin n_bad++; $display("FAIL other_listen: got ok%b l%b want ok1 l0", ok, listening); end
    s0 = sa_count;
    ctl_send(8'h60, 1'b0, ok);
    n_cmp++; if ({ok, sa_count == s0} !== 2'b11) begin n_bad++; $display("FAIL stray_sa: got ok%b n%0d want ok1 n%0d", ok, sa_count, s0); end
    ctl_send(8'h28, 1'b0, ok);
    n_cmp++; if ({ok, listening} !== 2'b11) begin n_bad++; $display("FAIL relisten: got ok%b l%b want ok1 l1", ok, listening); end
    ctl_send(8'hF2, 1'b0, ok);
    n_cmp++; if (sa_count !== s0 + 1 || {sa_cmd_seen, sa_val_seen} !== {2'd2, 4'd2}) begin n_bad++; $display("FAIL sa_open: got n%0d %0d/%0d want n%0d 2/2", sa_count, sa_cmd_seen, sa_val_seen, s0 + 1); end
    ctl_send(8'h3F, 1'b0, ok);
    n_cmp++; if ({ok, listening} !== 2'b10) begin n_bad++; $display("FAIL unlisten: got ok%b l%b want ok1 l0", ok, listening); end
    ctl_send(8'h61, 1'b0, ok);
    n_cmp++; if (sa_count !== s0 + 1) begin n_bad++; $display("FAIL sa_after_unl: got n%0d want n%0d", sa_count, s0 + 1); end
    ctl_send(8'h48, 1'b0, ok);
    ctl_send(8'hE3, 1'b0, ok);
    n_cmp++; if (sa_count !== s0 + 2 || {sa_cmd_seen, sa_val_seen} !== {2'd1, 4'd3}) begin n_bad++; $display("FAIL sa_close: got n%0d %0d/%0d want n%0d 1/3", sa_count, sa_cmd_seen, sa_val_seen, s0 + 2); end
    ctl_send(8'h65, 1'b0, ok);
    n_cmp++; if (sa_count !== s0 + 2) begin n_bad++; $display("FAIL sa_after_sa: got n%0d want n%0d", sa_count, s0 + 2); end
    ctl_send(8'h4A, 1'b0, ok);
    n_cmp++; if ({ok, talking} !== 2'b10) begin n_bad++; $display("FAIL other_talk: got ok%b t%b want ok1 t0", ok, talking); end
  endtask

  task automatic test_reset_accept();
    logic ok;
    ctl_send(8'h28, 1'b0, ok);
    atn_i = 1'b1;
    wait_line(L_READY, 1'b1, ok);
    data_i = ~8'h99;
    ce_tick();
    dav_i = 1'b0;
    wait_line(L_NDAC, 1'b1, ok);
    n_cmp++; if ({ok, rx_valid, rx_data} !== {2'b11, 8'h99}) begin n_bad++; $display("FAIL accept_pre: got ok%b v%b %h want ok1 v1 99", ok, rx_valid, rx_data); end
    reset = 1'b1;
    #1;
    n_cmp++; if ({nrfd_o, ndac_o, dav_o, eoi_o, data_o} !== {4'hF, 8'hFF}) begin n_bad++; $display("FAIL areset_lines: got %b %h want 1111 ff", {nrfd_o, ndac_o, dav_o, eoi_o}, data_o); end
    n_cmp++; if ({rx_valid, listening} !== 2'b00) begin n_bad++; $display("FAIL areset_flags: got v%b l%b want v0 l0", rx_valid, listening); end
    dav_i = 1'b1;
    data_i = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    data_i = 8'hFF;
    atn_i = 1'b1; dav_i = 1'b1; eoi_i = 1'b1; nrfd_i = 1'b1; ndac_i = 1'b1;
    rx_ack = 1'b0;
    tx_data = 8'h00; tx_eoi = 1'b0; tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    ce_tick();
    test_reset();
    test_listen_sa();
    test_rx();
    test_talk();
    test_abort();
    test_commands();
    test_reset_accept();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
